dino_jump_physics: RTL and testbench
====================================

# dino_jump_physics

Per-frame vertical motion controller for the dino sprite. It turns a raw jump button into a jump trajectory under constant gravity and drives the `dinoY` bus consumed by the dino pixel renderer and collision logic. It advances once per frame tick, paced by the same level-style `frameClk` the renderer uses, and only while the game is in the running state.

## Interface
- `GROUND_Y`, 8'd90: `dinoY` value when the dino stands on the ground (screen y grows downward).
- `JUMP_VEL`, -8'sd7: signed launch velocity in px/tick; negative means up.
- `GRAVITY`, 8'sd1: signed velocity increment applied each airborne tick.
- `MAX_FALL`, 8'sd8: saturation limit on downward (positive) velocity.
- `clk`, in, 1: system clock.
- `resetn`, in, 1: reset, synchronous, active-low; clock clk.
- `frameClk`, in, 1: frame pulse/level; one tick is taken per high phase.
- `jumpBtn`, in, 1: raw asynchronous jump button, active-high.
- `gameState`, in, 4: game FSM state; motion is enabled only when `gameState == GAME_RUNNING` (value taken from the shared game constants header).
- `dinoY`, out, 8: top row of the dino sprite.
- `airborne`, out, 1: high while in state AIR.
- `landed`, out, 1: one-clk pulse on the landing tick.

## Operation
- Tick generation: `tick = frameClk & ~frameHandled`. `frameHandled` is set on the tick and cleared on any clk where `frameClk == 0`. This gives exactly one tick per frameClk high phase, regardless of its width.
- Button path:
  - Two-flop synchronizer, then a rising-edge detect against the previous synced value.
  - A detected edge sets `jumpPending`.
  - The next tick consumes `jumpPending`. The tick uses the registered value from before that edge. An edge detected on the same clk as a tick leaves `jumpPending` set for the following tick.
- State machine: GROUND, AIR.
  - **GROUND, tick, running, jumpPending:** `dinoY <= GROUND_Y + JUMP_VEL`, `vel <= JUMP_VEL + GRAVITY`, go to AIR, clear pending.
  - **GROUND, tick, otherwise:** hold; clear pending.
  - **AIR, tick, running:** compute `nextY = dinoY + vel` as signed 10-bit. Then:
    - If `vel > 0` and `nextY >= GROUND_Y`: `dinoY <= GROUND_Y`, `vel <= 0`, go to GROUND, `landed = 1` for one clk.
    - Else if `nextY < 0`: `dinoY <= 0`, `vel <= vel + GRAVITY`.
    - Else: `dinoY <= nextY[7:0]`, `vel <= min(vel + GRAVITY, MAX_FALL)`.
    - Pending is discarded on airborne ticks; there is no buffered double jump.
- Not running (any gameState other than GAME_RUNNING): ticks freeze `dinoY`, `vel` and state, and clear pending. Motion resumes from the frozen point once running returns.
- Velocity register: signed 8-bit; all arithmetic is sign-extended.

## Timing
- Reset values: `dinoY = GROUND_Y`, `vel = 0`, state GROUND, `airborne = 0`, `landed = 0`, `jumpPending = 0`, `frameHandled = 0`, synchronizer flops 0.
- Reset mid-jump: the next clk returns all registers to the reset values; no landed pulse.
- Tick latency: registers update at the first clk edge where `frameClk == 1` and `frameHandled == 0`.
- Button latency: a `jumpBtn` rising edge sampled at edge N sets `jumpPending` at edge N+2.
- `airborne` is a registered decode of state and changes on the same edge as `dinoY`. `landed` asserts on the landing edge and clears on the next clk.
- Default trajectory from launch tick:
  - `dinoY` per tick: 83, 77, 72, 68, 65, 63, 62, 62, 63, 65, 68, 72, 77, 83, then 90 with landed on tick 15.
  - Peak is 62; the dino is airborne for 14 ticks.

## Test plan
- **Reset and idle:** hold `resetn = 0` for 3 clk, then run ticks with no button → `dinoY = 90`, `airborne = 0`, `landed` never asserts.
- **Full jump:** running, press `jumpBtn`, then issue 15 ticks → `dinoY` follows 83…83 exactly as listed above. Tick 15 gives `dinoY = 90`, a single-clk `landed`, and `airborne` falls.
- **Tick width:** hold `frameClk` high for 20 clk during a jump → exactly one trajectory step; a short 1-clk high phase also gives exactly one step.
- **Double press:** press again at tick 5 of a jump → ignored. Landing occurs at tick 15 as normal and no relaunch follows.
- **Pause:** set `gameState` to non-running at `dinoY = 68` (tick 4) for 10 ticks → `dinoY` holds at 68. After resume, the next tick gives 65.
- **Press/tick coincidence:** edge detect on the same clk as a tick → no launch on that tick; launch (`dinoY = 83`) on the next tick.

Source files
------------

// File: rtl/dino_jump_physics_if.sv
// Purpose: groups the frame/button/game-state inputs and the dino position
//          outputs of the jump physics block into one bundle.
// Ports: frameClk, jumpBtn, gameState (to physics); dinoY, airborne, landed (from physics).
interface dino_jump_physics_if;
  logic       frameClk;
  logic       jumpBtn;
  logic [3:0] gameState;
  logic [7:0] dinoY;
  logic       airborne;
  logic       landed;

  // master: the game/frame side that drives stimulus and consumes the position
  modport master (
    output frameClk, jumpBtn, gameState,
    input  dinoY, airborne, landed
  );

  // slave: the physics block itself
  modport slave (
    input  frameClk, jumpBtn, gameState,
    output dinoY, airborne, landed
  );
endinterface

// File: rtl/dino_jump_physics.sv
// Purpose: per-frame vertical motion of the dino sprite (jump under constant gravity).
// Latency: one frame tick per frameClk high phase; outputs update on that tick's clk edge.
// Ports: clk, resetn (sync, active-low), bus (frameClk, jumpBtn, gameState in; dinoY, airborne, landed out).
module dino_jump_physics #(
  parameter logic        [7:0] GROUND_Y     = 8'd90,
  parameter logic signed [7:0] JUMP_VEL     = -8'sd7,
  parameter logic signed [7:0] GRAVITY      = 8'sd1,
  parameter logic signed [7:0] MAX_FALL     = 8'sd8,
  parameter logic        [3:0] GAME_RUNNING = 4'd1
) (
  input logic                 clk,
  input logic                 resetn,
  dino_jump_physics_if.slave  bus
);

  typedef enum logic {GROUND, AIR} stateT;

  stateT              state, stateNext;
  logic        [7:0]  dinoY, dinoYNext;
  logic signed [7:0]  vel, velNext;
  logic               airborne, landed, landedNext;
  logic               frameHandled, jumpPending;
  logic               btnSync1, btnSync2, btnPrev;
  logic               tick, btnEdge, running;
  logic signed [9:0]  nextY, launchY;
  logic signed [8:0]  velInc;

  // One tick per frameClk high phase, however many clks the phase lasts.
  assign tick    = bus.frameClk & ~frameHandled;
  assign btnEdge = btnSync2 & ~btnPrev;
  assign running = (bus.gameState == GAME_RUNNING);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      frameHandled <= 1'b0;
      btnSync1     <= 1'b0;
      btnSync2     <= 1'b0;
      btnPrev      <= 1'b0;
      jumpPending  <= 1'b0;
    end else begin
      if (!bus.frameClk)
        frameHandled <= 1'b0;
      else if (tick)
        frameHandled <= 1'b1;
      btnSync1 <= bus.jumpBtn;
      btnSync2 <= btnSync1;
      btnPrev  <= btnSync2;
      // Every tick consumes the pending flag (launch, discard or freeze);
      // an edge arriving on the tick clk survives for the next tick.
      jumpPending <= btnEdge | (jumpPending & ~tick);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= GROUND;
      dinoY    <= GROUND_Y;
      vel      <= 8'sd0;
      airborne <= 1'b0;
      landed   <= 1'b0;
    end else begin
      state    <= stateNext;
      dinoY    <= dinoYNext;
      vel      <= velNext;
      airborne <= (stateNext == AIR);
      landed   <= landedNext;
    end
  end

  always_comb begin
    stateNext  = state;
    dinoYNext  = dinoY;
    velNext    = vel;
    landedNext = 1'b0;
    // 10-bit signed math so upward overshoot past row 0 is visible as negative.
    nextY   = $signed({2'b00, dinoY}) + $signed({{2{vel[7]}}, vel});
    launchY = $signed({2'b00, GROUND_Y}) + $signed({{2{JUMP_VEL[7]}}, JUMP_VEL});
    velInc  = $signed({vel[7], vel}) + $signed({GRAVITY[7], GRAVITY});

    if (tick && running) begin
      case (state)
        GROUND: begin
          if (jumpPending) begin
            dinoYNext = launchY[7:0];
            velNext   = JUMP_VEL + GRAVITY;
            stateNext = AIR;
          end
        end
        AIR: begin
          if ((vel > 8'sd0) && (nextY >= $signed({2'b00, GROUND_Y}))) begin
            dinoYNext  = GROUND_Y;
            velNext    = 8'sd0;
            stateNext  = GROUND;
            landedNext = 1'b1;
          end else if (nextY < 10'sd0) begin
            dinoYNext = 8'd0;
            velNext   = velInc[7:0];
          end else begin
            dinoYNext = nextY[7:0];
            velNext   = (velInc > $signed({MAX_FALL[7], MAX_FALL})) ? MAX_FALL : velInc[7:0];
          end
        end
        default: stateNext = GROUND;
      endcase
    end
  end

  assign bus.dinoY    = dinoY;
  assign bus.airborne = airborne;
  assign bus.landed   = landed;

endmodule

// File: tb/tb_dino_jump_physics.sv
// Purpose: directed self-checking bench for dino_jump_physics.
// Ports: none; drives the interface from tasks, samples on falling clk edges.
module tb_dino_jump_physics;
  localparam logic [3:0] RUN  = 4'd1;
  localparam logic [3:0] IDLE = 4'd0;

  logic clk;
  logic resetn;
  int   testsRun  = 0;
  int   testsFail = 0;
  int   landedCount = 0;
  int   traj [15] = '{83, 77, 72, 68, 65, 63, 62, 62, 63, 65, 68, 72, 77, 83, 90};

  dino_jump_physics_if bus ();

  dino_jump_physics dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts clks with landed high, so a stretched pulse shows up as extra landings.
  always @(negedge clk) if (bus.landed) landedCount++;

  task automatic checkEq(input string tag, input int got, input int exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic doTick(input int width);
    bus.frameClk = 1'b1;
    repeat (width) @(negedge clk);
    bus.frameClk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pressBtn();
    bus.jumpBtn = 1'b1;
    repeat (4) @(negedge clk);
    bus.jumpBtn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic runTicks(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      doTick(2);
      checkEq($sformatf("%s_y%0d", tag, i + 1), int'(bus.dinoY), traj[i]);
      checkEq($sformatf("%s_air%0d", tag, i + 1), int'(bus.airborne), (i == 14) ? 0 : 1);
    end
  endtask

  initial begin
    resetn        = 1'b0;
    bus.frameClk  = 1'b0;
    bus.jumpBtn   = 1'b0;
    bus.gameState = RUN;
    repeat (3) @(negedge clk);
    checkEq("rst_y", int'(bus.dinoY), 90);
    checkEq("rst_air", int'(bus.airborne), 0);
    checkEq("rst_landed", int'(bus.landed), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Idle ticks, no button
    repeat (3) doTick(2);
    checkEq("idle_y", int'(bus.dinoY), 90);
    checkEq("idle_air", int'(bus.airborne), 0);
    checkEq("idle_landed", landedCount, 0);

    // Full jump, with a 20-clk and a 1-clk frame phase mixed in
    pressBtn();
    for (int i = 0; i < 15; i++) begin
      doTick((i == 2) ? 20 : ((i == 3) ? 1 : 2));
      checkEq($sformatf("jump_y%0d", i + 1), int'(bus.dinoY), traj[i]);
      checkEq($sformatf("jump_air%0d", i + 1), int'(bus.airborne), (i == 14) ? 0 : 1);
    end
    checkEq("jump_landed_cnt", landedCount, 1);

    // Double press mid-air is discarded
    pressBtn();
    runTicks(0, 4, "dbl");
    pressBtn();
    runTicks(5, 14, "dbl");
    checkEq("dbl_landed_cnt", landedCount, 2);
    repeat (2) doTick(2);
    checkEq("dbl_norelaunch_y", int'(bus.dinoY), 90);
    checkEq("dbl_norelaunch_air", int'(bus.airborne), 0);

    // Pause at the 68 point
    pressBtn();
    runTicks(0, 3, "pause");
    bus.gameState = IDLE;
    repeat (10) doTick(2);
    checkEq("pause_hold_y", int'(bus.dinoY), 68);
    checkEq("pause_hold_air", int'(bus.airborne), 1);
    bus.gameState = RUN;
    runTicks(4, 14, "resume");
    checkEq("pause_landed_cnt", landedCount, 3);

    // Button edge detected on the same clk as a tick
    bus.jumpBtn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.frameClk = 1'b1;
    @(negedge clk);
    bus.frameClk = 1'b0;
    checkEq("coinc_nolaunch_y", int'(bus.dinoY), 90);
    checkEq("coinc_nolaunch_air", int'(bus.airborne), 0);
    @(negedge clk);
    doTick(2);
    checkEq("coinc_launch_y", int'(bus.dinoY), 83);
    bus.jumpBtn = 1'b0;
    runTicks(1, 14, "coinc");
    checkEq("coinc_landed_cnt", landedCount, 4);

    // Reset mid-jump
    pressBtn();
    runTicks(0, 2, "rstmid");
    resetn = 1'b0;
    @(negedge clk);
    checkEq("rstmid_y", int'(bus.dinoY), 90);
    checkEq("rstmid_air", int'(bus.airborne), 0);
    resetn = 1'b1;
    @(negedge clk);
    doTick(2);
    checkEq("rstmid_after_y", int'(bus.dinoY), 90);
    checkEq("rstmid_landed_cnt", landedCount, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end
endmodule
